delay_timer_arbiter: RTL
========================

Name: delay_timer_arbiter

Overview:
- Shares one up-counter instance (WIDTH-bit, sync load/enable) between two requesters that each need a timed wait of a programmable number of cycles.
  - Example requesters: multicycle memory wait-states and a stall/bubble generator.
- Arbitrates round-robin, loads the counter, enables it until the granted length is reached, then pulses that requester's done.
- Sits beside the counter in the datapath. The counter's load/enable/data_in are driven only by this block.

Parameters:
- WIDTH, 8, width of the requested delay length and of the counter it controls.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req0  input  1  requester 0 wants a delay; level, held until done0
- len0  input  WIDTH  delay length for requester 0; sampled at grant
- req1  input  1  requester 1 wants a delay; level, held until done1
- len1  input  WIDTH  delay length for requester 1; sampled at grant
- cnt_value  input  WIDTH  current output of the shared counter
- cnt_load  output  1  load strobe to counter
- cnt_data_in  output  WIDTH  load value to counter; constant 0
- cnt_en  output  1  count-enable to counter
- gnt0  output  1  requester 0 currently owns the timer
- gnt1  output  1  requester 1 currently owns the timer
- done0  output  1  one-cycle pulse: requester 0 delay complete
- done1  output  1  one-cycle pulse: requester 1 delay complete
- busy  output  1  timer not idle

Behaviour:
- FSM states: IDLE, LOAD, COUNT, DONE. All outputs are decoded from registered state, owner and len_q, so outputs change only after a clock edge.
- Reset (rst=1 at an edge, any state, including mid-count):
  - state=IDLE, owner=0, last_owner=1 (so requester 0 wins the first tie), len_q=0.
  - All outputs 0: cnt_load, cnt_en, gnt0/1, done0/1, busy.
- IDLE -> LOAD when req0|req1:
  - If only one request is set, that requester wins.
  - If both are set, the winner is the requester that is not last_owner.
  - At that edge: owner is registered, len_q is loaded from the winner's len, and last_owner is updated to the winner.
  - No request: stay in IDLE.
- LOAD:
  - Outputs: cnt_load=1, cnt_data_in=0, gnt[owner]=1, busy=1.
  - Next state: COUNT, unconditionally.
- COUNT:
  - Outputs: gnt[owner]=1, busy=1, cnt_en=(cnt_value != len_q).
  - When cnt_value == len_q: next state DONE, and cnt_en=0 in that cycle.
- DONE:
  - Outputs: done[owner]=1 for exactly one cycle, gnt[owner]=1, busy=1, cnt_en=0.
  - Next state: IDLE.
- Latency:
  - Request first seen in IDLE at edge k: LOAD during cycle k+1, COUNT from k+2.
  - cnt_value reaches len_q at cycle k+2+len; done pulses in cycle k+3+len.
  - Total from grant edge to done = len+3 cycles. Back-to-back service adds one IDLE cycle.
- len=0: COUNT lasts exactly one cycle with cnt_en=0, then DONE.
- len=2^WIDTH-1: no wrap. The count stops at the maximum value and cnt_en drops before overflow.
- len0/len1 changes after grant are ignored, because len_q is frozen.
- Dropping req during a grant:
  - Does not abort; the sequence completes and done still pulses.
  - A requester that holds req through its done cycle is re-arbitrated in the following IDLE. Round-robin then favours the other requester if both are set.
- A request arriving while busy waits; there is no queueing beyond the level req.
- gnt0 and gnt1 are never both 1. done0 and done1 are never both 1.
- No arithmetic is performed inside this block; the comparison is an equality over WIDTH bits.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no req -> all outputs 0, busy=0, cnt_data_in=0.
- Single request, req0=1 len0=5:
  - gnt0 rises next cycle; cnt_load=1 for 1 cycle.
  - cnt_en=1 for exactly 5 cycles, with cnt_value counting 0..5.
  - done0 pulses at grant+8 cycles; gnt0 and busy drop the cycle after.
- Tie and round-robin: req0=req1=1 from reset, len0=2, len1=3, both held through their done:
  - Grant order 0,1,0,1.
  - done0 spaced 5 cycles after grant0; done1 6 cycles after grant1.
  - gnt one-hot throughout.
- Boundaries:
  - len1=0 -> done1 exactly 3 cycles after grant1, with cnt_en never asserted.
  - len0=255 (WIDTH=8) -> cnt_en high for 255 cycles and cnt_value ends at 255 without wrapping to 0.
- Len change and req drop mid-count: grant req0 with len0=10, then set len0=3 and drop req0 at count 4 -> counting continues to 10 and done0 still pulses.
- Reset mid-operation: rst=1 during COUNT at cnt_value=4 -> next cycle all outputs 0 and state IDLE; a pending req1 is granted the cycle after rst is released.

Source files
------------

// File: rtl/delay_timer_arbiter.sv
// Round-robin arbiter that lends one shared up-counter to two requesters
// for programmable-length waits, pulsing the owner's done when the wait ends.
module delay_timer_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] len0,
    input  logic             req1,
    input  logic [WIDTH-1:0] len1,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_data_in,
    output logic             cnt_en,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_owner_q, last_owner_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic             winner;
    logic             at_len;

    // On a tie the requester that did not win last time is served.
    assign winner = (req0 && req1) ? ~last_owner_q : req1;
    assign at_len = (cnt_value == len_q);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        len_d        = len_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d      = LOAD;
                    owner_d      = winner;
                    last_owner_d = winner;
                    len_d        = winner ? len1 : len0;
                end
            end
            LOAD:  state_d = COUNT;
            COUNT: if (at_len) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            len_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            len_q        <= len_d;
        end
    end

    // cnt_en drops in the cycle the count matches, so the counter never wraps.
    assign busy        = (state_q != IDLE);
    assign cnt_load    = (state_q == LOAD);
    assign cnt_data_in = '0;
    assign cnt_en      = (state_q == COUNT) && !at_len;
    assign gnt0        = busy && !owner_q;
    assign gnt1        = busy && owner_q;
    assign done0       = (state_q == DONE) && !owner_q;
    assign done1       = (state_q == DONE) && owner_q;
    assign state_o     = state_q;

endmodule
